// File: rtl/seg_scan_pkg.sv
// Shared constants and state encoding for the seven-segment scan path.
package seg_scan_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_e;

  localparam logic [7:0] SEG_OFF = 8'h00;

  localparam int DEF_N_DIGITS  = 6;
  localparam int DEF_SCAN_DIV  = 1000;
  localparam int DEF_BLANK_CYC = 8;

endpackage

// File: rtl/seg_scan_driver_if.sv
// Control, frame data and display bus between the counter chain and the scanner.
interface seg_scan_driver_if
  import seg_scan_pkg::*;
#(
  parameter int N_DIGITS = DEF_N_DIGITS
);
  logic                    en;
  logic                    load;
  logic [8*N_DIGITS-1:0]   seg_data_in;
  logic [7:0]              seg_out;
  logic [N_DIGITS-1:0]     com_out;
  logic                    frame_done;

  modport master (
    output en, load, seg_data_in,
    input  seg_out, com_out, frame_done
  );

  modport slave (
    input  en, load, seg_data_in,
    output seg_out, com_out, frame_done
  );
endinterface

// File: rtl/scan_slot_timer.sv
// Per-digit slot counter: flags the last blank cycle, the cycle before slot end,
// and the slot end itself.
module scan_slot_timer
  import seg_scan_pkg::*;
#(
  parameter int SCAN_DIV  = DEF_SCAN_DIV,
  parameter int BLANK_CYC = DEF_BLANK_CYC
) (
  input  logic clk_in,
  input  logic rst,
  input  logic i_restart,
  output logic o_blank_end,
  output logic o_pre_end,
  output logic o_slot_end
);
  localparam int CNT_W = $clog2(SCAN_DIV);

  logic [CNT_W-1:0] r_cnt;

  assign o_blank_end = (r_cnt == CNT_W'(BLANK_CYC - 1));
  assign o_pre_end   = (r_cnt == CNT_W'(SCAN_DIV - 2));
  assign o_slot_end  = (r_cnt == CNT_W'(SCAN_DIV - 1));

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst)                         r_cnt <= '0;
    else if (i_restart || o_slot_end) r_cnt <= '0;
    else                             r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment scanner with double-buffered frame data and
// a blanking gap at the start of every digit slot.
module seg_scan_driver
  import seg_scan_pkg::*;
#(
  parameter int N_DIGITS  = DEF_N_DIGITS,
  parameter int SCAN_DIV  = DEF_SCAN_DIV,
  parameter int BLANK_CYC = DEF_BLANK_CYC
) (
  input logic              clk_in,
  input logic              rst,
  seg_scan_driver_if.slave bus
);
  localparam int DIG_W = $clog2(N_DIGITS);
  localparam logic [DIG_W-1:0] LAST_DIG = DIG_W'(N_DIGITS - 1);

  scan_state_e                 r_state, w_state_nxt;
  logic [DIG_W-1:0]            r_digit, w_digit_nxt;
  logic                        r_run;
  logic [N_DIGITS-1:0][7:0]    r_pend, r_active, w_data;
  logic [7:0]                  r_seg;
  logic [N_DIGITS-1:0]         r_com, w_com_nxt;
  logic                        r_fd, w_fd_nxt;
  logic                        w_boundary, w_restart;
  logic                        w_blank_end, w_pre_end, w_slot_end;

  assign w_data    = bus.seg_data_in;
  // r_run low means the next enabled edge is a fresh start of digit 0
  assign w_restart = !bus.en || !r_run;

  scan_slot_timer #(
    .SCAN_DIV  (SCAN_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) u_timer (
    .clk_in      (clk_in),
    .rst         (rst),
    .i_restart   (w_restart),
    .o_blank_end (w_blank_end),
    .o_pre_end   (w_pre_end),
    .o_slot_end  (w_slot_end)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_digit_nxt = r_digit;
    w_boundary  = 1'b0;
    if (!bus.en) begin
      w_state_nxt = ST_BLANK;
      w_digit_nxt = '0;
    end else if (!r_run) begin
      w_state_nxt = ST_BLANK;
      w_digit_nxt = '0;
      w_boundary  = 1'b1;
    end else begin
      case (r_state)
        ST_BLANK: if (w_blank_end) w_state_nxt = ST_DRIVE;
        ST_DRIVE: if (w_slot_end) begin
          w_state_nxt = ST_BLANK;
          if (r_digit == LAST_DIG) begin
            w_digit_nxt = '0;
            w_boundary  = 1'b1;
          end else begin
            w_digit_nxt = r_digit + 1'b1;
          end
        end
        default: w_state_nxt = ST_BLANK;
      endcase
    end
  end

  // Outputs are registered from next-state so they switch on the same edge as the FSM
  assign w_com_nxt = (w_state_nxt == ST_DRIVE) ? (N_DIGITS'(1) << w_digit_nxt) : '0;
  assign w_fd_nxt  = bus.en && r_run && w_pre_end && (r_digit == LAST_DIG);

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_state  <= ST_BLANK;
      r_digit  <= '0;
      r_run    <= 1'b0;
      r_pend   <= '0;
      r_active <= '0;
      r_seg    <= SEG_OFF;
      r_com    <= '0;
      r_fd     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_digit <= w_digit_nxt;
      r_run   <= bus.en;
      if (bus.load)  r_pend   <= w_data;
      if (w_boundary) r_active <= bus.load ? w_data : r_pend;
      r_com   <= w_com_nxt;
      r_seg   <= (w_state_nxt == ST_DRIVE) ? r_active[w_digit_nxt] : SEG_OFF;
      r_fd    <= w_fd_nxt;
    end
  end

  assign bus.seg_out    = r_seg;
  assign bus.com_out    = r_com;
  assign bus.frame_done = r_fd;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with N_DIGITS=2, SCAN_DIV=4, BLANK_CYC=1.
module tb_seg_scan_driver;

  logic clk_in = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  seg_scan_driver_if #(.N_DIGITS(2)) bus ();

  seg_scan_driver #(
    .N_DIGITS  (2),
    .SCAN_DIV  (4),
    .BLANK_CYC (1)
  ) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Expected values for position pos (0..7) in a frame showing 16-bit data d
  function automatic logic [1:0] exp_com(input int pos);
    if (pos >= 1 && pos <= 3) return 2'b01;
    if (pos >= 5 && pos <= 7) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [7:0] exp_seg(input int pos, input logic [15:0] d);
    if (pos >= 1 && pos <= 3) return d[7:0];
    if (pos >= 5 && pos <= 7) return d[15:8];
    return 8'h00;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.en = 1'b0;
    bus.load = 1'b0;
    bus.seg_data_in = '0;
    #2;
    n_checks++;
    if (bus.com_out !== 2'b00 || bus.seg_out !== 8'h00 || bus.frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: com=%b seg=%h fd=%b want 00/00/0", bus.com_out, bus.seg_out, bus.frame_done);
    end
    repeat (2) tick();
    n_checks++;
    if (bus.com_out !== 2'b00 || bus.seg_out !== 8'h00 || bus.frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold: com=%b seg=%h fd=%b want 00/00/0", bus.com_out, bus.seg_out, bus.frame_done);
    end
    rst = 1'b0;
    bus.en = 1'b1;
  endtask

  // Frames E1..E8 still show the reset buffer; E9..E16 show the load made at E2
  task automatic test_scan_latency();
    logic [15:0] d;
    int pos;
    for (int k = 1; k <= 16; k++) begin
      tick();
      pos = (k - 1) % 8;
      d = (k <= 8) ? 16'h0000 : 16'hA53C;
      n_checks++;
      if (bus.com_out !== exp_com(pos)) begin
        n_fail++;
        $display("FAIL scan_com E%0d: got %b want %b", k, bus.com_out, exp_com(pos));
      end
      n_checks++;
      if (bus.seg_out !== exp_seg(pos, d)) begin
        n_fail++;
        $display("FAIL scan_seg E%0d: got %h want %h", k, bus.seg_out, exp_seg(pos, d));
      end
      n_checks++;
      if (bus.frame_done !== (pos == 7)) begin
        n_fail++;
        $display("FAIL scan_fd E%0d: got %b want %b", k, bus.frame_done, pos == 7);
      end
      if (k == 1) begin
        bus.load = 1'b1;
        bus.seg_data_in = 16'hA53C;
      end else if (k == 2) begin
        bus.load = 1'b0;
        bus.seg_data_in = '0;
      end
    end
  endtask

  task automatic test_midframe_load();
    logic [15:0] d;
    int pos;
    for (int k = 17; k <= 32; k++) begin
      tick();
      pos = (k - 1) % 8;
      d = (k <= 24) ? 16'hA53C : 16'h1234;
      n_checks++;
      if (bus.com_out !== exp_com(pos) || bus.seg_out !== exp_seg(pos, d)) begin
        n_fail++;
        $display("FAIL midframe E%0d: com=%b seg=%h want %b/%h", k, bus.com_out, bus.seg_out,
                 exp_com(pos), exp_seg(pos, d));
      end
      if (k == 18) begin
        bus.load = 1'b1;
        bus.seg_data_in = 16'h1234;
      end else if (k == 19) begin
        bus.load = 1'b0;
        bus.seg_data_in = '0;
      end
    end
  endtask

  task automatic test_boundary_load();
    int pos;
    bus.load = 1'b1;
    bus.seg_data_in = 16'h5566;
    for (int k = 33; k <= 40; k++) begin
      tick();
      if (k == 33) begin
        bus.load = 1'b0;
        bus.seg_data_in = '0;
      end
      pos = (k - 1) % 8;
      n_checks++;
      if (bus.com_out !== exp_com(pos) || bus.seg_out !== exp_seg(pos, 16'h5566)) begin
        n_fail++;
        $display("FAIL boundary_load E%0d: com=%b seg=%h want %b/%h", k, bus.com_out, bus.seg_out,
                 exp_com(pos), exp_seg(pos, 16'h5566));
      end
    end
  endtask

  task automatic test_frame_done();
    int pulses = 0;
    int first = -1;
    int last = -1;
    logic bad_bus = 1'b0;
    for (int k = 41; k <= 56; k++) begin
      tick();
      if (bus.frame_done === 1'b1) begin
        pulses++;
        if (first < 0) first = k;
        last = k;
        if (bus.com_out !== 2'b10) bad_bus = 1'b1;
      end
    end
    n_checks++;
    if (pulses != 2) begin
      n_fail++;
      $display("FAIL fd_count: got %0d pulses want 2", pulses);
    end
    n_checks++;
    if (first != 48 || last - first != 8) begin
      n_fail++;
      $display("FAIL fd_spacing: first=E%0d gap=%0d want E48/8", first, last - first);
    end
    n_checks++;
    if (bad_bus) begin
      n_fail++;
      $display("FAIL fd_phase: pulse not during digit 1 drive");
    end
  endtask

  task automatic test_en_drop();
    int pos;
    repeat (6) tick();  // E57..E62, digit 1 drive
    n_checks++;
    if (bus.com_out !== 2'b10 || bus.seg_out !== 8'h55) begin
      n_fail++;
      $display("FAIL en_pre: com=%b seg=%h want 10/55", bus.com_out, bus.seg_out);
    end
    bus.en = 1'b0;
    bus.load = 1'b1;
    bus.seg_data_in = 16'h7788;
    tick();
    bus.load = 1'b0;
    bus.seg_data_in = '0;
    n_checks++;
    if (bus.com_out !== 2'b00 || bus.seg_out !== 8'h00 || bus.frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL en_off: com=%b seg=%h fd=%b want 00/00/0", bus.com_out, bus.seg_out, bus.frame_done);
    end
    tick();
    n_checks++;
    if (bus.com_out !== 2'b00 || bus.seg_out !== 8'h00) begin
      n_fail++;
      $display("FAIL en_off_hold: com=%b seg=%h want 00/00", bus.com_out, bus.seg_out);
    end
    bus.en = 1'b1;
    // Restart is a frame boundary, so the load made while disabled shows at once
    for (int k = 1; k <= 8; k++) begin
      tick();
      pos = k - 1;
      n_checks++;
      if (bus.com_out !== exp_com(pos) || bus.seg_out !== exp_seg(pos, 16'h7788) ||
          bus.frame_done !== (pos == 7)) begin
        n_fail++;
        $display("FAIL en_restart c%0d: com=%b seg=%h fd=%b want %b/%h/%b", k, bus.com_out,
                 bus.seg_out, bus.frame_done, exp_com(pos), exp_seg(pos, 16'h7788), pos == 7);
      end
    end
  endtask

  task automatic test_async_reset();
    int pos;
    repeat (8) tick();  // to the last drive cycle of the next frame
    n_checks++;
    if (bus.com_out !== 2'b10 || bus.seg_out !== 8'h77 || bus.frame_done !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pre: com=%b seg=%h fd=%b want 10/77/1", bus.com_out, bus.seg_out, bus.frame_done);
    end
    #3;
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.com_out !== 2'b00 || bus.seg_out !== 8'h00 || bus.frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid: com=%b seg=%h fd=%b want 00/00/0", bus.com_out, bus.seg_out, bus.frame_done);
    end
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      pos = k - 1;
      n_checks++;
      if (bus.com_out !== exp_com(pos) || bus.seg_out !== 8'h00) begin
        n_fail++;
        $display("FAIL rst_after c%0d: com=%b seg=%h want %b/00", k, bus.com_out, bus.seg_out,
                 exp_com(pos));
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan_latency();
    test_midframe_load();
    test_boundary_load();
    test_frame_done();
    test_en_drop();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Time-multiplexed seven-segment display scanner for the clock display path. It takes the per-digit segment bytes produced by the counter/BCD-to-segment chain and drives one shared 8-bit segment bus plus one-hot digit enables. Each digit is lit in turn with a blanking gap against ghosting. A double-buffered shadow keeps every displayed frame consistent.

## Interface
- N_DIGITS, 6, number of digits scanned (2..8)
- SCAN_DIV, 1000, clock cycles per digit slot (blank + drive)
- BLANK_CYC, 8, cycles of each slot with all digits off; 1 <= BLANK_CYC < SCAN_DIV

- clk_in  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- en  input  1  scan enable; 0 forces the display dark and restarts the scan
- load  input  1  one-cycle strobe; capture seg_data_in into the pending buffer
- seg_data_in  input  8*N_DIGITS  digit k segment byte at bits [8k+7:8k]; digit 0 = rightmost
- seg_out  output  8  shared segment bus, active-high, registered
- com_out  output  N_DIGITS  digit enables, one-hot active-high or all-zero, registered
- frame_done  output  1  one-cycle pulse at the end of the last digit's drive phase

## Operation
- Buffers: pending (written by load) and active (displayed). Both reset to all zero.
- The active buffer takes the pending value only at a frame boundary: the cycle that enters BLANK for digit 0.
- If load coincides with the boundary cycle, seg_data_in goes into both pending and active that cycle.
- FSM states: BLANK, DRIVE.
  - BLANK: com_out = 0, seg_out = 8'h00. Lasts BLANK_CYC cycles, then goes to DRIVE.
  - DRIVE: com_out = one-hot(digit), seg_out = active[digit]. Lasts SCAN_DIV-BLANK_CYC cycles, then goes to BLANK.
  - Leaving DRIVE: digit increments. When digit = N_DIGITS-1, digit wraps to 0, frame_done pulses, and the buffer transfer occurs.
- Slot counter: $clog2(SCAN_DIV) bits. It counts 0..SCAN_DIV-1 and wraps to 0 on the BLANK entry.
- en=0: the next edge forces BLANK, digit 0, and slot count 0. Outputs are dark and frame_done stays 0. Load still updates pending.
- en 0->1: the first cycle is the BLANK of digit 0, and this counts as a frame boundary (transfer occurs).
- Reset mid-frame: all state returns to reset values immediately, with no partial-slot completion.

## Timing
- Reset values:
  - seg_out = 8'h00, com_out = 0, frame_done = 0
  - state BLANK, digit 0, slot count 0
  - both buffers 0
- After reset release, the first BLANK of digit 0 starts on the first clock edge. Drive of digit 0 begins BLANK_CYC cycles later.
- Outputs are registered, so com_out/seg_out change on the same edge as the state change and never glitch between digits.
- Frame period = N_DIGITS*SCAN_DIV cycles. frame_done has a period of exactly one frame while en=1.
- Load to visible latency: from the next frame boundary plus BLANK_CYC cycles, to one full frame later.
- seg_out is 0 whenever com_out is 0. com_out never has more than one bit set.

## Structure
- Shared package seg_scan_pkg holds:
  - state encoding (BLANK=1'b0, DRIVE=1'b1)
  - SEG_OFF = 8'h00
  - default N_DIGITS/SCAN_DIV/BLANK_CYC constants, reused by the top-level clock design
- One sub-module, scan_slot_timer: slot counter with a BLANK_CYC compare and a slot-end terminal pulse.
- The FSM, digit index, buffers and output registers stay in seg_scan_driver.

## Test plan
All cases use N_DIGITS=2, SCAN_DIV=4, BLANK_CYC=1 unless stated.
- Reset then en=1, load 16'hA53C at cycle 2:
  - 8 cycles later com_out sequence is 00,01,01,01,00,10,10,10
  - seg_out is 3C during digit 0 drive and A5 during digit 1 drive
- Load 16'h1234 mid-frame during digit 0 drive -> the frame continues with old data; the next frame shows 34 then 12.
- Load asserted on the boundary cycle with 16'h5566 -> that same frame shows 66 then 55.
- frame_done -> single pulses exactly 8 cycles apart, each on the last DRIVE cycle of digit 1.
- en=0 during digit 1 drive -> next cycle com_out=0 and seg_out=00. After en=1, digit 0 blank begins and no frame_done fires until 8 cycles later.
- Async rst asserted between edges mid-DRIVE -> com_out, seg_out and frame_done are 0 before the next edge. Buffers clear to 0, so the next frame shows 00 on both digits.
